// File: rtl/async_fifo_rd_stream_if.sv
// rtl/async_fifo_rd_stream_if.sv - valid/ready output stream bundle of the FIFO read adapter
//
// Ports (modports):
//   master : drives p_m_valid, p_m_data; samples p_m_ready (the adapter)
//   slave  : samples p_m_valid, p_m_data; drives p_m_ready (the consumer)
interface async_fifo_rd_stream_if #(
    parameter int BITS = 32
);
    logic            p_m_valid;
    logic            p_m_ready;
    logic [BITS-1:0] p_m_data;

    modport master (output p_m_valid, output p_m_data, input p_m_ready);
    modport slave  (input p_m_valid, input p_m_data, output p_m_ready);
endinterface

// File: rtl/async_fifo_rd_stream.sv
// rtl/async_fifo_rd_stream.sv - FIFO read port to first-word-fall-through stream adapter
//
// Turns a registered-read FIFO port (read_en/empty, data one cycle later) into a
// valid/ready stream, prefetching into a small circular buffer so a consumer that
// holds ready high receives one beat per cycle. p_flush discards buffered and
// in-flight words.
//
// Ports:
//   read_clk, read_rst_n  clock, asynchronous active-low reset
//   p_fifo_read_en        out  read request to the FIFO
//   p_fifo_read_data      in   FIFO data, valid the cycle after an accepted read
//   p_fifo_read_empty     in   FIFO empty flag
//   p_flush               in   synchronous flush
//   m                     stream master (p_m_valid, p_m_ready, p_m_data)
//   p_level               out  entries held in the local buffer
module async_fifo_rd_stream #(
    parameter  int BITS      = 32,
    parameter  int BUF_DEPTH = 2,
    localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                         read_clk,
    input  logic                         read_rst_n,
    output logic                         p_fifo_read_en,
    input  logic [BITS-1:0]              p_fifo_read_data,
    input  logic                         p_fifo_read_empty,
    input  logic                         p_flush,
    async_fifo_rd_stream_if.master       m,
    output logic [LVL_W-1:0]             p_level
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [LVL_W-1:0] occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BITS-1:0]  buf_q [BUF_DEPTH];
    logic [BITS-1:0]  buf_d [BUF_DEPTH];

    logic             valid;
    logic             pop;
    logic             capture;
    logic             issue;
    logic [LVL_W:0]   committed;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        occ_d      = occ_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_d      = buf_q;

        valid = (occ_q != '0);
        pop   = valid & m.p_m_ready;

        // Slots already spoken for after this cycle: held words plus the word
        // in flight, minus the one leaving now. Issue only if one stays free.
        committed = {1'b0, occ_q} + (LVL_W + 1)'(inflight_q) - (LVL_W + 1)'(pop);
        issue     = !p_fifo_read_empty & !p_flush & (committed < (LVL_W + 1)'(BUF_DEPTH));

        // The FIFO data port holds stale values except the cycle after a read.
        capture = inflight_q & !p_flush;

        if (p_flush) begin
            occ_d      = '0;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (capture) begin
                buf_d[wr_ptr_q] = p_fifo_read_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            occ_d      = occ_q + LVL_W'(capture) - LVL_W'(pop);
            inflight_d = issue;
        end
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_q      <= buf_d;
        end
    end

    // Reset gates the request directly since the FIFO may be non-empty in reset.
    assign p_fifo_read_en = issue & read_rst_n;
    assign m.p_m_valid    = valid;
    assign m.p_m_data     = buf_q[rd_ptr_q];
    assign p_level        = occ_q;
endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb/tb_async_fifo_rd_stream.sv - scoreboard bench for async_fifo_rd_stream
module tb_async_fifo_rd_stream;
    localparam int BITS  = 32;
    localparam int DEPTH = 2;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             rd_en;
    logic [BITS-1:0]  rd_data = '0;
    logic             empty;
    logic [LVL_W-1:0] level;

    async_fifo_rd_stream_if #(.BITS(BITS)) m_if();

    async_fifo_rd_stream #(.BITS(BITS), .BUF_DEPTH(DEPTH)) dut (
        .read_clk          (clk),
        .read_rst_n        (rst_n),
        .p_fifo_read_en    (rd_en),
        .p_fifo_read_data  (rd_data),
        .p_fifo_read_empty (empty),
        .p_flush           (flush),
        .m                 (m_if),
        .p_level           (level)
    );

    always #5 clk = ~clk;

    // FIFO model: words written into src by the stimulus, read with one cycle latency.
    logic [BITS-1:0] src [4096];
    int wr_idx = 0;
    int rd_idx = 0;
    int read_count = 0;
    assign empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data    <= src[rd_idx];
            rd_idx     <= rd_idx + 1;
            read_count <= read_count + 1;
        end
    end

    logic [BITS-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BITS-1:0] w);
        src[wr_idx] = w;
        wr_idx++;
        exp_q.push_back(w);
    endtask

    task automatic discard(input int n);
        repeat (n) void'(exp_q.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
        step();
        step();
    endtask

    // Monitor: pops the scoreboard on each accepted beat, checks hold and level bound.
    logic            hold_q = 1'b0;
    logic [BITS-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (level > LVL_W'(DEPTH)) begin
                errors++;
                $display("FAIL level_bound: got %0d max %0d", level, DEPTH);
            end
            if (hold_q) begin
                checks++;
                if (!m_if.p_m_valid || m_if.p_m_data !== hold_data) begin
                    errors++;
                    $display("FAIL hold_stable: got valid %b data %h expected valid 1 data %h",
                             m_if.p_m_valid, m_if.p_m_data, hold_data);
                end
            end
            hold_q    <= m_if.p_m_valid & !m_if.p_m_ready & !flush;
            hold_data <= m_if.p_m_data;
            if (m_if.p_m_valid && m_if.p_m_ready && !flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got %h expected no beat", m_if.p_m_data);
                end else begin
                    logic [BITS-1:0] e;
                    e = exp_q.pop_front();
                    if (m_if.p_m_data !== e) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h", m_if.p_m_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int base;
        m_if.p_m_ready = 1'b0;

        // 1: reset with FIFO non-empty
        push(32'h11);
        push(32'h22);
        push(32'h33);
        step();
        step();
        chk("rst_read_en", rd_en, 0);
        chk("rst_valid", m_if.p_m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", m_if.p_m_data, 0);
        rst_n = 1'b1;
        m_if.p_m_ready = 1'b1;
        #1;
        chk("release_read_en", rd_en, 1);

        // 2: latency T+2, then back-to-back beats
        step();
        chk("t1_read_count", read_count, 1);
        chk("t1_valid", m_if.p_m_valid, 0);
        step();
        chk("t2_valid", m_if.p_m_valid, 1);
        chk("t2_data", m_if.p_m_data, 32'h11);
        step();
        chk("t3_data", m_if.p_m_data, 32'h22);
        step();
        chk("t4_data", m_if.p_m_data, 32'h33);
        step();
        chk("t5_valid", m_if.p_m_valid, 0);
        chk("t5_level", level, 0);

        // 3: backpressure fills exactly DEPTH entries, then gapless drain
        m_if.p_m_ready = 1'b0;
        base = read_count;
        for (int i = 0; i < 5; i++) push(32'hA0 + i);
        repeat (6) step();
        chk("bp_reads", read_count - base, 2);
        chk("bp_level", level, 2);
        chk("bp_head", m_if.p_m_data, 32'hA0);
        m_if.p_m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_gapless_valid", m_if.p_m_valid, 1);
            step();
        end
        chk("bp_after_valid", m_if.p_m_valid, 0);

        // 5: flush with one buffered and one in flight
        m_if.p_m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'hB0 + i);
        step();
        step();
        chk("fl_level_pre", level, 1);
        flush = 1'b1;
        #1;
        chk("fl_read_en", rd_en, 0);
        discard(2);
        step();
        flush = 1'b0;
        chk("fl_valid", m_if.p_m_valid, 0);
        chk("fl_level", level, 0);
        step();
        step();
        chk("fl_next_valid", m_if.p_m_valid, 1);
        chk("fl_next_data", m_if.p_m_data, 32'hB2);
        m_if.p_m_ready = 1'b1;
        drain(50);

        // 6: flush and pop in the same cycle
        m_if.p_m_ready = 1'b0;
        push(32'hC0);
        repeat (3) step();
        chk("fp_level_pre", level, 1);
        chk("fp_head", m_if.p_m_data, 32'hC0);
        flush = 1'b1;
        m_if.p_m_ready = 1'b1;
        discard(1);
        step();
        flush = 1'b0;
        m_if.p_m_ready = 1'b0;
        chk("fp_level", level, 0);
        chk("fp_valid", m_if.p_m_valid, 0);
        push(32'hC1);
        repeat (3) step();
        chk("fp_next_data", m_if.p_m_data, 32'hC1);
        m_if.p_m_ready = 1'b1;
        drain(50);

        // 4: random ready, 1000 random words arriving irregularly
        pushed = 0;
        while (pushed < 1000) begin
            if ($urandom_range(1, 0) == 1) begin
                push($urandom);
                pushed++;
            end
            m_if.p_m_ready = ($urandom_range(1, 0) == 1);
            step();
        end
        m_if.p_m_ready = 1'b1;
        drain(4000);
        chk("rand_end_valid", m_if.p_m_valid, 0);
        chk("rand_all_read", rd_idx, wr_idx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
